// File: rtl/multi_edge_detector_pkg.sv
// Shared definitions for the multi-channel edge detector: mode encodings
// and the filter counter sizing helper.
package multi_edge_detector_pkg;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Filter counter width: clog2(cycles), never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/multi_edge_detector_channel.sv
// One channel: synchroniser, stability filter, edge pulses, mode
// qualification, sticky pending flag and saturating event counter.
module edge_channel
  import multi_edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int COUNT_W       = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_sig,
  input  logic [1:0]         i_mode,
  input  logic               i_clear,
  input  logic               i_count_clr,
  output logic               o_level,
  output logic               o_rise_pulse,
  output logic               o_fall_pulse,
  output logic               o_event_pulse,
  output logic               o_pending,
  output logic [COUNT_W-1:0] o_event_count
);

  localparam int               CNT_W    = cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_pending;
  logic [COUNT_W-1:0]     r_count;

  logic w_sync_q;
  logic w_rise_en;
  logic w_fall_en;
  logic w_event;

  assign w_sync_q  = r_sync[SYNC_STAGES-1];
  assign w_rise_en = (i_mode == MODE_RISE) || (i_mode == MODE_BOTH);
  assign w_fall_en = (i_mode == MODE_FALL) || (i_mode == MODE_BOTH);
  // Mode is applied combinationally so a mode change affects the same cycle.
  assign w_event   = (r_rise & w_rise_en) | (r_fall & w_fall_en);

  // Synchroniser shift chain; bit 0 is the metastability-exposed stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_sync <= '0;
    else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
  end

  // Stability filter: accept a new level only after it holds FILTER_CYCLES
  // cycles; any return to the current level restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (w_sync_q == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_sync_q;
        r_cnt   <= '0;
        r_rise  <= w_sync_q;
        r_fall  <= ~w_sync_q;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Sticky pending flag; a new event beats a same-cycle clear.
  always_ff @(posedge i_clk) begin
    if (i_reset)      r_pending <= 1'b0;
    else if (w_event) r_pending <= 1'b1;
    else if (i_clear) r_pending <= 1'b0;
  end

  // Saturating event counter; clear beats a same-cycle event.
  always_ff @(posedge i_clk) begin
    if (i_reset)                    r_count <= '0;
    else if (i_count_clr)           r_count <= '0;
    else if (w_event && ~&r_count)  r_count <= r_count + COUNT_W'(1);
  end

  assign o_level       = r_level;
  assign o_rise_pulse  = r_rise;
  assign o_fall_pulse  = r_fall;
  assign o_event_pulse = w_event;
  assign o_pending     = r_pending;
  assign o_event_count = r_count;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel debounced edge detector: CHANNELS independent edge_channel
// instances with a combined interrupt over all pending flags.
module multi_edge_detector
  import multi_edge_detector_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int COUNT_W       = 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [CHANNELS-1:0]         i_sig_in,
  input  logic [2*CHANNELS-1:0]       i_mode,
  input  logic [CHANNELS-1:0]         i_clear,
  input  logic [CHANNELS-1:0]         i_count_clr,
  output logic [CHANNELS-1:0]         o_level,
  output logic [CHANNELS-1:0]         o_rise_pulse,
  output logic [CHANNELS-1:0]         o_fall_pulse,
  output logic [CHANNELS-1:0]         o_event_pulse,
  output logic [CHANNELS-1:0]         o_pending,
  output logic                        o_irq,
  output logic [CHANNELS*COUNT_W-1:0] o_event_count
);

  // One self-contained channel per input bit.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .COUNT_W      (COUNT_W)
    ) u_ch (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_sig        (i_sig_in[g]),
      .i_mode       (i_mode[2*g +: 2]),
      .i_clear      (i_clear[g]),
      .i_count_clr  (i_count_clr[g]),
      .o_level      (o_level[g]),
      .o_rise_pulse (o_rise_pulse[g]),
      .o_fall_pulse (o_fall_pulse[g]),
      .o_event_pulse(o_event_pulse[g]),
      .o_pending    (o_pending[g]),
      .o_event_count(o_event_count[g*COUNT_W +: COUNT_W])
    );
  end

  assign o_irq = |o_pending;

endmodule
